sign_extend_add_decode: RTL and testbench

SIGN_EXTEND_ADD_DECODE -- requirements
Module: sign_extend_add_decode

---
 rtl/sign_extend_add_decode.sv | 105 ++++++++++
 tb/tb_sign_extend_add_decode.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sign_extend_add_decode.sv
// Single-stage registered MIPS helper: sign-extends the immediate, adds two
// operands with carry-out, and runs the main control decoder.
module sign_extend_add_decode #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              valid_out,
    output logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              branch,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              jump,
    output logic [1:0]        alu_op,
    output logic              illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [15:0] v);
        return DATA_W'(v);
    endfunction

    // Result is {reg_write,reg_dst,alu_src,branch,mem_write,mem_to_reg,alu_op,jump,illegal}
    function automatic logic [9:0] decode(input logic [5:0] op);
        case (op)
            OP_RTYPE: return 10'b110000100_0;
            OP_LW:    return 10'b101001000_0;
            OP_SW:    return 10'b001010000_0;
            OP_BEQ:   return 10'b000100010_0;
            OP_ADDI:  return 10'b101000000_0;
            OP_J:     return 10'b000000001_0;
            default:  return 10'b000000000_1;
        endcase
    endfunction

    logic              valid_d,   valid_q;
    logic [DATA_W-1:0] imm_ext_d, imm_ext_q;
    logic [DATA_W-1:0] sum_d,     sum_q;
    logic              carry_d,   carry_q;
    logic [9:0]        dec_d,     dec_q;
    logic [DATA_W:0]   sum_full;

    always_comb begin
        sum_full  = {1'b0, src_a} + {1'b0, src_b};
        valid_d   = valid_in;
        imm_ext_d = imm_ext_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        dec_d     = dec_q;
        if (valid_in) begin
            imm_ext_d = sign_ext(imm);
            sum_d     = sum_full[DATA_W-1:0];
            carry_d   = sum_full[DATA_W];
            dec_d     = decode(opcode);
        end
    end

    // Output register stage; reset clears everything so no stale result survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            imm_ext_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            dec_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            imm_ext_q <= imm_ext_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            dec_q     <= dec_d;
        end
    end

    assign valid_out  = valid_q;
    assign imm_ext    = imm_ext_q;
    assign sum        = sum_q;
    assign carry_out  = carry_q;
    assign reg_write  = dec_q[9];
    assign reg_dst    = dec_q[8];
    assign alu_src    = dec_q[7];
    assign branch     = dec_q[6];
    assign mem_write  = dec_q[5];
    assign mem_to_reg = dec_q[4];
    assign alu_op     = dec_q[3:2];
    assign jump       = dec_q[1];
    assign illegal_op = dec_q[0];

endmodule

// File: tb/tb_sign_extend_add_decode.sv
// Directed bench for sign_extend_add_decode with immediate-assertion checks.
module tb_sign_extend_add_decode;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [5:0]  opcode;
    logic [15:0] imm;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        valid_out;
    logic [31:0] imm_ext;
    logic [31:0] sum;
    logic        carry_out;
    logic        reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump;
    logic [1:0]  alu_op;
    logic        illegal_op;

    int tests_run;
    int tests_failed;

    sign_extend_add_decode #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
        .imm(imm), .src_a(src_a), .src_b(src_b), .valid_out(valid_out),
        .imm_ext(imm_ext), .sum(sum), .carry_out(carry_out),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .branch(branch), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .jump(jump), .alu_op(alu_op), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_obs();
        return {22'd0, reg_write, reg_dst, alu_src, branch, mem_write,
                mem_to_reg, alu_op, jump, illegal_op};
    endfunction

    task automatic step(input logic v, input logic [5:0] op, input logic [15:0] im,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_in = v; opcode = op; imm = im; src_a = a; src_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ie,
                           input logic [31:0] s, input logic c, input logic [9:0] ctl);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, ".imm_ext"}, imm_ext, ie);
        chk({tag, ".sum"}, sum, s);
        chk({tag, ".carry"}, {31'd0, carry_out}, {31'd0, c});
        chk({tag, ".ctrl"}, ctrl_obs(), {22'd0, ctl});
    endtask

    initial begin
        logic [15:0] iv;
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        valid_in = 1'b1; opcode = 6'b100011; imm = 16'h8000;
        src_a = 32'hFFFF_FFFF; src_b = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 10'b000000000_0);

        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;

        // Opcode sweep with distinct data patterns
        step(1'b1, 6'b000000, 16'h7FFF, 32'd999, 32'd1);
        chk_out("rtype", 1'b1, 32'h0000_7FFF, 32'd1000, 1'b0, 10'b110000100_0);
        step(1'b1, 6'b100011, 16'h8000, 32'hFFFF_FFFF, 32'h1);
        chk_out("lw", 1'b1, 32'hFFFF_8000, 32'h0, 1'b1, 10'b101001000_0);
        step(1'b1, 6'b101011, 16'h0000, 32'h1234_5678, 32'h1111_1111);
        chk_out("sw", 1'b1, 32'h0, 32'h2345_6789, 1'b0, 10'b001010000_0);
        step(1'b1, 6'b000100, 16'hFFFF, 32'h8000_0000, 32'h8000_0000);
        chk_out("beq", 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 10'b000100010_0);
        step(1'b1, 6'b001000, 16'h1234, 32'h7FFF_FFFF, 32'h1);
        chk_out("addi", 1'b1, 32'h0000_1234, 32'h8000_0000, 1'b0, 10'b101000000_0);
        step(1'b1, 6'b000010, 16'hABCD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_out("j", 1'b1, 32'hFFFF_ABCD, 32'hFFFF_FFFE, 1'b1, 10'b000000001_0);

        // No combinational path: new inputs must not show before the edge
        @(negedge clk);
        valid_in = 1'b1; opcode = 6'b111111; imm = 16'h0001; src_a = 32'd5; src_b = 32'd6;
        #1;
        chk("no_comb.ctrl", ctrl_obs(), {22'd0, 10'b000000001_0});
        chk("no_comb.sum", sum, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        chk_out("illegal3f", 1'b1, 32'h1, 32'd11, 1'b0, 10'b000000000_1);
        step(1'b1, 6'b000001, 16'h4000, 32'd0, 32'd0);
        chk_out("illegal01", 1'b1, 32'h0000_4000, 32'h0, 1'b0, 10'b000000000_1);

        // Hold while valid_in is low
        step(1'b1, 6'b100011, 16'hFF00, 32'd100, 32'd23);
        chk_out("pre_hold", 1'b1, 32'hFFFF_FF00, 32'd123, 1'b0, 10'b101001000_0);
        step(1'b0, 6'b000000, 16'h0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_out("hold1", 1'b0, 32'hFFFF_FF00, 32'd123, 1'b0, 10'b101001000_0);
        step(1'b0, 6'b111111, 16'h8888, 32'd1, 32'd2);
        chk_out("hold2", 1'b0, 32'hFFFF_FF00, 32'd123, 1'b0, 10'b101001000_0);

        // Immediate sweep in steps of 257 (covers 0x0000 and 0xFFFF)
        for (int k = 0; k < 256; k++) begin
            iv = 16'(k * 257);
            step(1'b1, 6'b001000, iv, 32'd0, 32'd0);
            chk("sweep.lo", {16'd0, imm_ext[15:0]}, {16'd0, iv});
            chk("sweep.hi", {16'd0, imm_ext[31:16]}, iv[15] ? 32'h0000_FFFF : 32'h0);
        end

        // Asynchronous reset between edges discards the result
        step(1'b1, 6'b000000, 16'h8001, 32'hF000_0000, 32'h2000_0000);
        chk_out("pre_rst", 1'b1, 32'hFFFF_8001, 32'h1000_0000, 1'b1, 10'b110000100_0);
        #1;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 10'b000000000_0);
        #1;
        reset = 1'b0;
        step(1'b0, 6'b100011, 16'h1111, 32'd3, 32'd4);
        chk_out("post_rst_idle", 1'b0, 32'h0, 32'h0, 1'b0, 10'b000000000_0);
        step(1'b1, 6'b101011, 16'hC000, 32'd3, 32'd4);
        chk_out("post_rst_first", 1'b1, 32'hFFFF_C000, 32'd7, 1'b0, 10'b001010000_0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
